// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: default register-file geometry, the data word
// type and the pending-write counter type used by the register file.
package cpu_types_pkg;

    localparam int DEF_DW  = 32;
    localparam int DEF_AW  = 5;
    localparam int DEF_NRD = 2;
    localparam int DEF_PW  = 2;

    typedef logic [DEF_DW-1:0] word_t;
    typedef logic [DEF_PW-1:0] pend_t;

endpackage

// File: rtl/pend_scoreboard.sv
// Pending-write scoreboard: one saturating-by-backpressure counter per
// architectural register (register 0 is never tracked). Counts issued but
// not yet written-back results and produces the issue handshake.
module pend_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int NRD = DEF_NRD,
    parameter int PW  = DEF_PW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wen,
    input  logic [AW-1:0]            wsel,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_wsel,
    output logic                     iss_ready,
    input  logic                     flush,
    input  logic [NRD-1:0][AW-1:0]   rsel,
    output logic [NRD-1:0][PW-1:0]   pend_rd
);

    localparam int DEPTH = 1 << AW;

    logic [PW-1:0]    pend [DEPTH];
    logic [DEPTH-1:0] inc;
    logic [DEPTH-1:0] wr;
    logic             full;
    logic             same_wr;
    logic             accept;

    // Issue is refused only when the destination counter is at its maximum
    // and no write to that register retires one entry in the same cycle.
    always_comb begin
        full      = (pend[iss_wsel] == {PW{1'b1}});
        same_wr   = wen && (wsel == iss_wsel);
        iss_ready = (iss_wsel == '0) || !full || same_wr;
        accept    = iss_valid && iss_ready;
    end

    // Decode per-register increment and write strobes.
    always_comb begin
        inc = '0;
        wr  = '0;
        for (int r = 1; r < DEPTH; r++) begin
            inc[r] = accept && (iss_wsel == AW'(r));
            wr[r]  = wen && (wsel == AW'(r));
        end
    end

    // Counter update: flush wins over issue; issue+write cancel; a write to an
    // idle register leaves the counter at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < DEPTH; r++) pend[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < DEPTH; r++) pend[r] <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (inc[r] && !wr[r])
                    pend[r] <= pend[r] + 1'b1;
                else if (!inc[r] && wr[r] && (pend[r] != '0))
                    pend[r] <= pend[r] - 1'b1;
            end
        end
    end

    // Per-read-port view of the pending counters.
    always_comb begin
        for (int i = 0; i < NRD; i++) pend_rd[i] = pend[rsel[i]];
    end

endmodule

// File: rtl/bypass_regfile.sv
// Register file with per-register pending-write tracking and combinational
// read ports. Register 0 is hard-wired to zero.
// Optional feature: define RF_BYPASS_EN to forward same-cycle writeback data
// to matching read ports (and clear busy when that write retires the last
// outstanding result).
module bypass_regfile
    import cpu_types_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int NRD = DEF_NRD,
    parameter int PW  = DEF_PW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wen,
    input  logic [AW-1:0]            wsel,
    input  logic [DW-1:0]            wdat,
    input  logic [NRD-1:0][AW-1:0]   rsel,
    output logic [NRD-1:0][DW-1:0]   rdat,
    output logic [NRD-1:0]           busy,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_wsel,
    output logic                     iss_ready,
    input  logic                     flush
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]            mem [DEPTH];
    logic [NRD-1:0][PW-1:0]   pend_rd;

    pend_scoreboard #(
        .AW  (AW),
        .NRD (NRD),
        .PW  (PW)
    ) u_pend (
        .CLK       (CLK),
        .RST       (RST),
        .wen       (wen),
        .wsel      (wsel),
        .iss_valid (iss_valid),
        .iss_wsel  (iss_wsel),
        .iss_ready (iss_ready),
        .flush     (flush),
        .rsel      (rsel),
        .pend_rd   (pend_rd)
    );

    // Storage: register 0 is never written so it always reads zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else if (wen && (wsel != '0)) begin
            mem[wsel] <= wdat;
        end
    end

`ifdef RF_BYPASS_EN
    // Read mux with forwarding; forwarding is suppressed while in reset so
    // the file reads zero throughout.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            if (!RST && wen && (wsel != '0) && (wsel == rsel[i])) begin
                rdat[i] = wdat;
                busy[i] = (pend_rd[i] > PW'(1));
            end else begin
                rdat[i] = mem[rsel[i]];
                busy[i] = (pend_rd[i] != '0);
            end
        end
    end
`else
    // Read mux straight from storage; busy reflects the pre-edge counters.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdat[i] = mem[rsel[i]];
            busy[i] = (pend_rd[i] != '0);
        end
    end
`endif

endmodule

// File: tb/tb_bypass_regfile.sv
// Self-checking bench for bypass_regfile: directed table, hand-written
// multi-cycle sequences and a randomized phase against a behavioural model.
module tb_bypass_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int PW = 2;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   CLK;
    logic                   RST;
    logic                   wen;
    logic [AW-1:0]          wsel;
    logic [DW-1:0]          wdat;
    logic [NRD-1:0][AW-1:0] rsel;
    logic [NRD-1:0][DW-1:0] rdat;
    logic [NRD-1:0]         busy;
    logic                   iss_valid;
    logic [AW-1:0]          iss_wsel;
    logic                   iss_ready;
    logic                   flush;

    int checks = 0;
    int errors = 0;

    bypass_regfile #(.DW(DW), .AW(AW), .NRD(NRD), .PW(PW)) dut (
        .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat), .busy(busy), .iss_valid(iss_valid),
        .iss_wsel(iss_wsel), .iss_ready(iss_ready), .flush(flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        iv;
        logic [4:0]  iw;
        logic        fl;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        er;
    } vec_t;

    vec_t tbl [11];

    // model state
    logic [31:0] mem_m  [32];
    int          pend_m [32];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle();
        wen = 0; wsel = '0; wdat = '0; rsel = '0;
        iss_valid = 0; iss_wsel = '0; flush = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        for (int r = 0; r < 32; r++) begin mem_m[r] = '0; pend_m[r] = 0; end
    endtask

    initial begin
        RST = 1'b1;
        idle();

        //            wen wsel wdat          rs0 rs1 iv iw fl e0            e1            eb     er
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1};
        tbl[1]  = '{1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1};
        tbl[2]  = '{1'b1, 5'd7, 32'h12345678, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 5'd3, 1'b0, 32'h12345678, 32'h0, 2'b00, 1'b1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b1, 5'd3, 1'b0, 32'h0, 32'h12345678, 2'b01, 1'b1};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 2'b11, 1'b1};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0};
        tbl[7]  = '{1'b1, 5'd3, 32'h33,       5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 32'h12345678, 32'h12345678, 2'b00, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b0, 5'd3, 1'b0, 32'h33, 32'h0, 2'b01, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 32'h33, 32'h0, 2'b01, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd8, 1'b0, 5'd8, 1'b0, 32'h33, 32'h0, 2'b00, 1'b1};

        // outputs while reset is held
        rsel[0] = 5'd5; rsel[1] = 5'd5;
        #3;
        chk("rst_rdat", {rdat[1], rdat[0]}, 64'h0);
        chk("rst_busy", busy, 2'b00);
        chk("rst_ready", iss_ready, 1'b1);
        do_reset();

        // directed table
        for (int k = 0; k < 11; k++) begin
            wen = tbl[k].wen; wsel = tbl[k].wsel; wdat = tbl[k].wdat;
            rsel[0] = tbl[k].rs0; rsel[1] = tbl[k].rs1;
            iss_valid = tbl[k].iv; iss_wsel = tbl[k].iw; flush = tbl[k].fl;
            #2;
            chk($sformatf("tbl%0d_rdat0", k), rdat[0], tbl[k].e0);
            chk($sformatf("tbl%0d_rdat1", k), rdat[1], tbl[k].e1);
            chk($sformatf("tbl%0d_busy", k), busy, tbl[k].eb);
            chk($sformatf("tbl%0d_ready", k), iss_ready, tbl[k].er);
            tick();
        end

        // writeback collision with an outstanding issue
        do_reset();
        wen = 1; wsel = 5'd9; wdat = 32'h99; tick();
        idle(); iss_valid = 1; iss_wsel = 5'd9; tick();
        idle(); wen = 1; wsel = 5'd9; wdat = 32'hA5A5A5A5; rsel[0] = 5'd9; rsel[1] = 5'd9;
        #2;
        chk("byp_rdat0", rdat[0], BYP ? 32'hA5A5A5A5 : 32'h99);
        chk("byp_rdat1", rdat[1], BYP ? 32'hA5A5A5A5 : 32'h99);
        chk("byp_busy", busy, BYP ? 2'b00 : 2'b11);
        tick();
        wen = 0; #2;
        chk("byp_after_rdat", rdat[0], 32'hA5A5A5A5);
        chk("byp_after_busy", busy, 2'b00);
        tick();

        // flush wins over issue
        idle(); iss_valid = 1; iss_wsel = 5'd4; tick();
        iss_wsel = 5'd6; tick();
        iss_wsel = 5'd8; flush = 1; rsel[0] = 5'd4; rsel[1] = 5'd6;
        #2;
        chk("fl_pre_busy", busy, 2'b11);
        chk("fl_ready", iss_ready, 1'b1);
        tick();
        idle(); rsel[0] = 5'd4; rsel[1] = 5'd6; #2;
        chk("fl_busy_4_6", busy, 2'b00);
        rsel[0] = 5'd8; rsel[1] = 5'd8; #1;
        chk("fl_busy_8", busy, 2'b00);
        tick();

        // reset mid-stream
        idle(); wen = 1; wsel = 5'd2; wdat = 32'h77; tick();
        idle(); iss_valid = 1; iss_wsel = 5'd2; tick(); tick();
        idle(); rsel[0] = 5'd2; rsel[1] = 5'd2; #2;
        chk("mid_pre_rdat", rdat[0], 32'h77);
        chk("mid_pre_busy", busy, 2'b11);
        RST = 1'b1; #1;
        chk("mid_rst_rdat", {rdat[1], rdat[0]}, 64'h0);
        chk("mid_rst_busy", busy, 2'b00);
        tick();
        RST = 1'b0; #2;
        chk("mid_post_rdat", rdat[0], 32'h0);
        chk("mid_post_busy", busy, 2'b00);
        tick();

        // randomized phase against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic        r_rst;
            logic [31:0] e_rd [2];
            logic [1:0]  e_bz;
            logic        e_rdy;
            bit          acc;
            r_rst     = ($urandom_range(0, 99) < 3);
            wen       = ($urandom_range(0, 99) < 40);
            wsel      = 5'($urandom_range(0, 7));
            wdat      = $urandom;
            rsel[0]   = 5'($urandom_range(0, 7));
            rsel[1]   = ($urandom_range(0, 3) == 0) ? rsel[0] : 5'($urandom_range(0, 7));
            iss_valid = ($urandom_range(0, 99) < 60);
            iss_wsel  = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 99) < 3);
            RST       = r_rst;
            if (r_rst)
                for (int r = 0; r < 32; r++) begin mem_m[r] = '0; pend_m[r] = 0; end

            // expectations from the rules
            e_rdy = (iss_wsel == 0) || (pend_m[iss_wsel] != 3) || (wen && wsel == iss_wsel);
            for (int i = 0; i < 2; i++) begin
                bit hit;
                int p;
                hit = BYP && !r_rst && wen && (wsel != 0) && (wsel == rsel[i]);
                p = (rsel[i] == 0) ? 0 : pend_m[rsel[i]];
                e_rd[i] = hit ? wdat : ((rsel[i] == 0) ? 32'h0 : mem_m[rsel[i]]);
                e_bz[i] = hit ? (p > 1) : (p > 0);
            end
            if (r_rst) e_rdy = 1'b1;
            #2;
            chk("rnd_rdat0", rdat[0], e_rd[0]);
            chk("rnd_rdat1", rdat[1], e_rd[1]);
            chk("rnd_busy", busy, e_bz);
            chk("rnd_ready", iss_ready, e_rdy);

            // model update at the edge
            if (!r_rst) begin
                acc = iss_valid && e_rdy;
                if (flush) begin
                    for (int r = 0; r < 32; r++) pend_m[r] = 0;
                end else begin
                    if (acc && iss_wsel != 0 && !(wen && wsel == iss_wsel))
                        pend_m[iss_wsel] = pend_m[iss_wsel] + 1;
                    if (wen && wsel != 0 && !(acc && wsel == iss_wsel) && pend_m[wsel] > 0)
                        pend_m[wsel] = pend_m[wsel] - 1;
                end
                if (wen && wsel != 0) mem_m[wsel] = wdat;
            end
            tick();
        end

        RST = 1'b0;
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
